// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Beat counter width; wide enough for the largest allowed burst of 15.
    localparam int BURST_CW = 4;

    // Number of bits needed to hold an index in 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: finds the first set request after the previous owner,
// wrapping modulo NREQ so a lone requester can re-win after itself.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    int   cand;
    logic found;

    // Walk last+1, last+2, ... last+NREQ and take the first request seen.
    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (!found && req[IDW'(cand)]) begin
                idx   = IDW'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port among NREQ
// requesters. The owner keeps the port until its last beat, BURST beats, or
// until it withdraws; each release costs one IDLE cycle.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int BURST  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr,
    output logic [DWIDTH-1:0]        fifo_wdata,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     busy
);

    localparam int IDW = clog2(NREQ);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      owner_q, owner_d;
    logic [IDW-1:0]      last_owner_q, last_owner_d;
    logic [BURST_CW-1:0] beat_cnt_q, beat_cnt_d;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic           owner_valid;
    logic           owner_last;
    logic           granted;
    logic           accept;

    rr_priority_picker #(.NREQ(NREQ)) u_picker (
        .req  (req_valid),
        .last (last_owner_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign granted     = (state_q == GRANT) && !reset;
    assign accept      = granted && owner_valid && !fifo_full;

    assign fifo_wr  = accept;
    assign grant_id = owner_q;
    assign busy     = (state_q == GRANT);

    // Only the owner sees ready, and never while the FIFO is full or in reset.
    always_comb begin
        req_ready = '0;
        if (granted && !fifo_full) begin
            req_ready[owner_q] = 1'b1;
        end
    end

    // Route the owner's data straight to the FIFO with no added latency.
    always_comb begin
        fifo_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IDW'(i)) begin
                fifo_wdata = req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and decide release in GRANT.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!owner_valid) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + BURST_CW'(1);
                    if (owner_last || (beat_cnt_d == BURST_CW'(BURST))) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset makes requester 0 win first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDW'(NREQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule
